// File: rtl/reg_file.sv
// Register file with combinational read ports, write-through bypass and a
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module reg_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = ($clog2(NREGS) > 5) ? $clog2(NREGS) : 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   output logic [XLEN-1:0]  rd1,
   output logic [XLEN-1:0]  rd2,
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_addr,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             issue_en,
   input  logic [AW-1:0]    issue_rd,
   output logic             stall,
   output logic [NREGS-1:0] busy_vec
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] wb_sel;
   logic [NREGS-1:0] set_sel;

   logic             wb_hit;
   logic             byp1;
   logic             byp2;
   logic             byp_issue;
   logic [XLEN-1:0]  rf1;
   logic [XLEN-1:0]  rf2;
   logic             busy1;
   logic             busy2;
   logic             busy_issue;

   // Per-register decode; x0 and out-of-range addresses never select anything.
   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign wb_sel[gi]  = 1'b0;
            assign set_sel[gi] = 1'b0;
         end else begin : g_arch
            assign wb_sel[gi]  = wb_en && (wb_addr == AW'(gi));
            assign set_sel[gi] = issue_en && !stall && (issue_rd == AW'(gi));
         end
         assign regs_d[gi] = wb_sel[gi] ? wb_data : regs_q[gi];
         // Set after clear: a newer producer owns the register.
         assign busy_d[gi] = set_sel[gi] | (busy_q[gi] & ~wb_sel[gi]);
      end
   endgenerate

   assign wb_hit    = |wb_sel;
   assign byp1      = wb_hit && (wb_addr == rs1_addr);
   assign byp2      = wb_hit && (wb_addr == rs2_addr);
   assign byp_issue = wb_hit && (wb_addr == issue_rd);

   always_comb begin
      rf1        = '0;
      rf2        = '0;
      busy1      = 1'b0;
      busy2      = 1'b0;
      busy_issue = 1'b0;
      for (int i = 1; i < NREGS; i++) begin
         if (rs1_addr == AW'(i)) begin
            rf1   = regs_q[i];
            busy1 = busy_q[i];
         end
         if (rs2_addr == AW'(i)) begin
            rf2   = regs_q[i];
            busy2 = busy_q[i];
         end
         if (issue_rd == AW'(i)) begin
            busy_issue = busy_q[i];
         end
      end
   end

   assign rd1      = byp1 ? wb_data : rf1;
   assign rd2      = byp2 ? wb_data : rf2;
   assign stall    = (busy1 && !byp1) || (busy2 && !byp2) || (busy_issue && !byp_issue);
   assign busy_vec = busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: expected values are queued when stimulus
// is driven and popped when the combinational outputs are sampled.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr, wb_addr, issue_rd;
   logic [31:0] rd1, rd2, wb_data;
   logic        wb_en, issue_en, stall;
   logic [31:0] busy_vec;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model[32];
   logic [31:0] e;

   reg_file #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rd1(rd1), .rd2(rd2),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .issue_en(issue_en), .issue_rd(issue_rd),
      .stall(stall), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_en = 0; wb_addr = 0; wb_data = 0;
      issue_en = 0; issue_rd = 0;
      rs1_addr = 0; rs2_addr = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      #2;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (busy_vec !== e) begin errors++; $display("FAIL reset_busy got %h exp %h", busy_vec, e); end
      else $display("ok reset_busy %h", busy_vec);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, stall} !== e) begin errors++; $display("FAIL reset_stall got %b exp %0d", stall, e); end
      else $display("ok reset_stall %b", stall);
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd1, e); end
      else $display("ok reset_rd1 %h", rd1);
      #9 rst = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      logic [4:0] a;
      wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; model[5] = 32'hDEADBEEF;
      tick();
      idle(); rs1_addr = 5; rs2_addr = 0;
      exp_q.push_back(model[5]); exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL wr_rd1_x5 got %h exp %h", rd1, e); end
      else $display("ok wr_rd1_x5 %h", rd1);
      e = exp_q.pop_front(); checks++;
      if (rd2 !== e) begin errors++; $display("FAIL wr_rd2_x0 got %h exp %h", rd2, e); end
      else $display("ok wr_rd2_x0 %h", rd2);
      for (int k = 0; k < 6; k++) begin
         a = 5'($urandom_range(1, 31));
         @(posedge clk); #1;
         idle(); wb_en = 1; wb_addr = a; wb_data = $urandom; model[a] = wb_data;
         tick();
         idle(); rs1_addr = 5; rs2_addr = a;
         exp_q.push_back(model[a]);
         #1;
         e = exp_q.pop_front(); checks++;
         if (rd2 !== e) begin errors++; $display("FAIL rand_rd2_x%0d got %h exp %h", a, rd2, e); end
         else $display("ok rand_rd2_x%0d %h", a, rd2);
      end
   endtask

   task automatic test_x0();
      idle(); wb_en = 1; wb_addr = 0; wb_data = 32'h12345678;
      tick();
      idle(); rs1_addr = 0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL x0_rd1 got %h exp %h", rd1, e); end
      else $display("ok x0_rd1 %h", rd1);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, busy_vec[0]} !== e) begin errors++; $display("FAIL x0_busy got %b exp 0", busy_vec[0]); end
      else $display("ok x0_busy %b", busy_vec[0]);
   endtask

   task automatic test_bypass();
      idle(); wb_en = 1; wb_addr = 7; wb_data = 32'hA5A5A5A5; rs2_addr = 7; rs1_addr = 5;
      exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(model[5]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd2 !== e) begin errors++; $display("FAIL bypass_rd2 got %h exp %h", rd2, e); end
      else $display("ok bypass_rd2 %h", rd2);
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL bypass_rd1_nohit got %h exp %h", rd1, e); end
      else $display("ok bypass_rd1_nohit %h", rd1);
      model[7] = 32'hA5A5A5A5;
      tick();
   endtask

   task automatic test_scoreboard();
      idle(); issue_en = 1; issue_rd = 3;
      tick();
      idle(); rs1_addr = 3;
      exp_q.push_back(32'h1); exp_q.push_back(32'h0000_0008);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, stall} !== e) begin errors++; $display("FAIL raw_stall got %b exp 1", stall); end
      else $display("ok raw_stall %b", stall);
      e = exp_q.pop_front(); checks++;
      if (busy_vec !== e) begin errors++; $display("FAIL busy_set3 got %h exp %h", busy_vec, e); end
      else $display("ok busy_set3 %h", busy_vec);
      wb_en = 1; wb_addr = 3; wb_data = 32'h10; model[3] = 32'h10;
      exp_q.push_back(32'h0); exp_q.push_back(32'h10);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, stall} !== e) begin errors++; $display("FAIL wb_unstall got %b exp 0", stall); end
      else $display("ok wb_unstall %b", stall);
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL wb_rd1_x3 got %h exp %h", rd1, e); end
      else $display("ok wb_rd1_x3 %h", rd1);
      tick();
      idle();
      exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (busy_vec !== e) begin errors++; $display("FAIL busy_clr3 got %h exp %h", busy_vec, e); end
      else $display("ok busy_clr3 %h", busy_vec);
      // WAW hazard and stalled issue must not set a bit
      issue_en = 1; issue_rd = 9;
      tick();
      idle(); issue_en = 1; issue_rd = 9;
      exp_q.push_back(32'h1);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'h0, stall} !== e) begin errors++; $display("FAIL waw_stall got %b exp 1", stall); end
      else $display("ok waw_stall %b", stall);
      issue_rd = 10; rs1_addr = 9;
      tick();
      idle();
      exp_q.push_back(32'h0000_0200);
      #1;
      e = exp_q.pop_front(); checks++;
      if (busy_vec !== e) begin errors++; $display("FAIL stalled_noset got %h exp %h", busy_vec, e); end
      else $display("ok stalled_noset %h", busy_vec);
      wb_en = 1; wb_addr = 9; wb_data = 32'h99; model[9] = 32'h99;
      tick();
      idle();
   endtask

   task automatic test_same_edge();
      idle(); issue_en = 1; issue_rd = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h44; model[4] = 32'h44;
      tick();
      idle(); rs1_addr = 4;
      exp_q.push_back(32'h0000_0010); exp_q.push_back(32'h44); exp_q.push_back(32'h1);
      #1;
      e = exp_q.pop_front(); checks++;
      if (busy_vec !== e) begin errors++; $display("FAIL same_edge_busy got %h exp %h", busy_vec, e); end
      else $display("ok same_edge_busy %h", busy_vec);
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL same_edge_data got %h exp %h", rd1, e); end
      else $display("ok same_edge_data %h", rd1);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, stall} !== e) begin errors++; $display("FAIL same_edge_stall got %b exp 1", stall); end
      else $display("ok same_edge_stall %b", stall);
      wb_en = 1; wb_addr = 4; wb_data = 32'h45; model[4] = 32'h45;
      tick();
      idle(); wb_en = 1; wb_addr = 12; wb_data = 32'hC0FFEE12; model[12] = 32'hC0FFEE12;
      tick();
      idle(); rs1_addr = 12; rs2_addr = 4;
      exp_q.push_back(32'h0); exp_q.push_back(model[12]); exp_q.push_back(model[4]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (busy_vec !== e) begin errors++; $display("FAIL nonbusy_wb_busy got %h exp %h", busy_vec, e); end
      else $display("ok nonbusy_wb_busy %h", busy_vec);
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL nonbusy_wb_data got %h exp %h", rd1, e); end
      else $display("ok nonbusy_wb_data %h", rd1);
      e = exp_q.pop_front(); checks++;
      if (rd2 !== e) begin errors++; $display("FAIL x4_final got %h exp %h", rd2, e); end
      else $display("ok x4_final %h", rd2);
   endtask

   task automatic test_back_to_back();
      logic [4:0] prev;
      prev = 0;
      for (int k = 0; k < 8; k++) begin
         idle(); wb_en = 1; wb_addr = 5'(20 + k); wb_data = $urandom;
         rs1_addr = prev; rs2_addr = wb_addr;
         exp_q.push_back(model[prev]); exp_q.push_back(wb_data);
         #1;
         e = exp_q.pop_front(); checks++;
         if (rd1 !== e) begin errors++; $display("FAIL b2b_rd1_x%0d got %h exp %h", prev, rd1, e); end
         else $display("ok b2b_rd1_x%0d %h", prev, rd1);
         e = exp_q.pop_front(); checks++;
         if (rd2 !== e) begin errors++; $display("FAIL b2b_rd2_x%0d got %h exp %h", wb_addr, rd2, e); end
         else $display("ok b2b_rd2_x%0d %h", wb_addr, rd2);
         model[wb_addr] = wb_data;
         prev = wb_addr;
         tick();
      end
      idle();
   endtask

   task automatic test_async_reset();
      for (int i = 1; i < 32; i++) begin
         idle(); wb_en = 1; wb_addr = 5'(i); wb_data = 32'h01010101 * i; model[i] = wb_data;
         tick();
      end
      idle(); issue_en = 1; issue_rd = 20;
      tick();
      idle(); rs1_addr = 17; rs2_addr = 20;
      exp_q.push_back(model[17]); exp_q.push_back(32'h1);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL fill_rd1_x17 got %h exp %h", rd1, e); end
      else $display("ok fill_rd1_x17 %h", rd1);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, stall} !== e) begin errors++; $display("FAIL pre_rst_stall got %b exp 1", stall); end
      else $display("ok pre_rst_stall %b", stall);
      #2 rst = 1'b1;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL arst_rd1 got %h exp %h", rd1, e); end
      else $display("ok arst_rd1 %h", rd1);
      e = exp_q.pop_front(); checks++;
      if (rd2 !== e) begin errors++; $display("FAIL arst_rd2 got %h exp %h", rd2, e); end
      else $display("ok arst_rd2 %h", rd2);
      e = exp_q.pop_front(); checks++;
      if (busy_vec !== e) begin errors++; $display("FAIL arst_busy got %h exp %h", busy_vec, e); end
      else $display("ok arst_busy %h", busy_vec);
      e = exp_q.pop_front(); checks++;
      if ({31'h0, stall} !== e) begin errors++; $display("FAIL arst_stall got %b exp 0", stall); end
      else $display("ok arst_stall %b", stall);
      wb_en = 1; wb_addr = 6; wb_data = 32'h66; rs1_addr = 0; rs2_addr = 0;
      tick();
      rst = 1'b0;
      model[6] = 32'h66;
      tick();
      idle(); rs1_addr = 6; rs2_addr = 17;
      exp_q.push_back(model[6]); exp_q.push_back(model[17]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL first_write_x6 got %h exp %h", rd1, e); end
      else $display("ok first_write_x6 %h", rd1);
      e = exp_q.pop_front(); checks++;
      if (rd2 !== e) begin errors++; $display("FAIL post_rst_x17 got %h exp %h", rd2, e); end
      else $display("ok post_rst_x17 %h", rd2);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_x0();
      test_bypass();
      test_scoreboard();
      test_same_edge();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
